// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Port indices select bits of the one-hot grant vector.
package arb_pkg;

   localparam int PORT_D    = 0;
   localparam int PORT_I    = 1;
   localparam int NUM_PORTS = 2;

   function automatic int beWidth(input int dataWidth);
      return dataWidth / 8;
   endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles in which a pending fetch was denied.
// Once the count reaches the limit, fetch is forced to win the next tie.
module arb_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic fetchValid_i,
   input  logic fetchGrant_i,
   output logic forceFetch_o
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starveCnt_q, starveCnt_d;

   always_comb begin
      starveCnt_d = starveCnt_q;
      if (!fetchValid_i || fetchGrant_i) begin
         starveCnt_d = '0;
      end else if (starveCnt_q < LIMIT) begin
         starveCnt_d = starveCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starveCnt_q <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end

   assign forceFetch_o = (starveCnt_q >= LIMIT);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous-read BRAM between the data port and
// instruction fetch; data wins by default, starvation guard forces fetch.
module imem_dmem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               d_req_valid,
   output logic                               d_req_ready,
   input  logic [ADDR_WIDTH-1:0]              d_req_addr,
   input  logic [DATA_WIDTH-1:0]              d_req_wdata,
   input  logic [beWidth(DATA_WIDTH)-1:0]     d_req_wbe,
   output logic                               d_resp_valid,
   output logic [DATA_WIDTH-1:0]              d_resp_rdata,
   input  logic                               i_req_valid,
   output logic                               i_req_ready,
   input  logic [ADDR_WIDTH-1:0]              i_req_addr,
   output logic                               i_resp_valid,
   output logic [DATA_WIDTH-1:0]              i_resp_rdata,
   output logic                               mem_en,
   output logic [beWidth(DATA_WIDTH)-1:0]     mem_we,
   output logic [ADDR_WIDTH-1:0]              mem_addr,
   output logic [DATA_WIDTH-1:0]              mem_din,
   input  logic [DATA_WIDTH-1:0]              mem_dout,
   output logic [31:0]                        conflict_cnt
);

   logic                 forceFetch;
   logic [NUM_PORTS-1:0] grant;
   logic                 rdD_q, rdD_d;
   logic                 rdI_q, rdI_d;
   logic [31:0]          conflictCnt_q, conflictCnt_d;

   arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk_i        (clk),
      .rst_i        (rst),
      .fetchValid_i (i_req_valid),
      .fetchGrant_i (grant[PORT_I]),
      .forceFetch_o (forceFetch)
   );

   // Forced fetch only overrides data when fetch is actually requesting.
   always_comb begin
      grant = '0;
      if (!rst) begin
         if (d_req_valid && !(forceFetch && i_req_valid)) begin
            grant[PORT_D] = 1'b1;
         end else if (i_req_valid) begin
            grant[PORT_I] = 1'b1;
         end
      end
   end

   assign d_req_ready = grant[PORT_D];
   assign i_req_ready = grant[PORT_I];

   always_comb begin
      mem_en   = |grant;
      mem_we   = '0;
      mem_addr = d_req_addr;
      mem_din  = d_req_wdata;
      if (grant[PORT_I]) begin
         mem_addr = i_req_addr;
      end
      if (grant[PORT_D]) begin
         mem_we = d_req_wbe;
      end
   end

   always_comb begin
      rdD_d         = grant[PORT_D] && (d_req_wbe == '0);
      rdI_d         = grant[PORT_I];
      conflictCnt_d = conflictCnt_q + {31'd0, (d_req_valid && i_req_valid)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdD_q         <= 1'b0;
         rdI_q         <= 1'b0;
         conflictCnt_q <= '0;
      end else begin
         rdD_q         <= rdD_d;
         rdI_q         <= rdI_d;
         conflictCnt_q <= conflictCnt_d;
      end
   end

   // The gate on rst drops a response whose read was in flight when reset hit.
   assign d_resp_valid = rdD_q && !rst;
   assign i_resp_valid = rdI_q && !rst;
   assign d_resp_rdata = mem_dout;
   assign i_resp_rdata = mem_dout;
   assign conflict_cnt = conflictCnt_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter with a behavioural BRAM and a
// transaction-level reference model of grants, memory contents and responses.
module tb_imem_dmem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        d_req_valid = 1'b0;
   logic        d_req_ready;
   logic [11:0] d_req_addr = '0;
   logic [31:0] d_req_wdata = '0;
   logic [3:0]  d_req_wbe = '0;
   logic        d_resp_valid;
   logic [31:0] d_resp_rdata;
   logic        i_req_valid = 1'b0;
   logic        i_req_ready;
   logic [11:0] i_req_addr = '0;
   logic        i_resp_valid;
   logic [31:0] i_resp_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic [31:0] conflict_cnt;

   int nTests = 0;
   int nFail  = 0;

   imem_dmem_arbiter #(
      .ADDR_WIDTH   (12),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_req_addr   (d_req_addr),
      .d_req_wdata  (d_req_wdata),
      .d_req_wbe    (d_req_wbe),
      .d_resp_valid (d_resp_valid),
      .d_resp_rdata (d_resp_rdata),
      .i_req_valid  (i_req_valid),
      .i_req_ready  (i_req_ready),
      .i_req_addr   (i_req_addr),
      .i_resp_valid (i_resp_valid),
      .i_resp_rdata (i_resp_rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  be);
      logic [31:0] w;
      w = oldWord;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) w[8*b +: 8] = newWord[8*b +: 8];
      end
      return w;
   endfunction

   // Behavioural single-port BRAM with a preload path used while in reset.
   logic [31:0] bram [0:15];
   logic        loadEn = 1'b0;
   logic [3:0]  loadAddr = '0;
   logic [31:0] loadData = '0;

   always @(posedge clk) begin
      if (loadEn) begin
         bram[loadAddr] <= loadData;
      end else if (mem_en) begin
         if (mem_we != 4'b0000) begin
            bram[mem_addr[3:0]] <= mergeBytes(bram[mem_addr[3:0]], mem_din, mem_we);
         end else begin
            mem_dout <= bram[mem_addr[3:0]];
         end
      end
   end

   // Reference model state
   logic [31:0] refMem [0:15];
   int          expStarve = 0;
   logic [31:0] expConflict = '0;
   logic        expDValid = 1'b0;
   logic [31:0] expDData = '0;
   logic        expIValid = 1'b0;
   logic [31:0] expIData = '0;
   logic        obsIReady;
   logic        obsDValid;
   logic [31:0] obsDData;
   logic        obsIValid;
   logic [31:0] obsIData;

   // One clock of stimulus: drive, check at negedge, advance model, step edge.
   task automatic step(input logic dv, input logic [11:0] da, input logic [31:0] dw,
                       input logic [3:0] dbe, input logic iv, input logic [11:0] ia);
      logic forceI, gd, gi;
      d_req_valid = dv;
      d_req_addr  = da;
      d_req_wdata = dw;
      d_req_wbe   = dbe;
      i_req_valid = iv;
      i_req_addr  = ia;
      forceI = (expStarve >= LIMIT);
      gd = !rst && dv && !(forceI && iv);
      gi = !rst && iv && !gd;
      @(negedge clk);
      obsIReady = i_req_ready;
      obsDValid = d_resp_valid;
      obsDData  = d_resp_rdata;
      obsIValid = i_resp_valid;
      obsIData  = i_resp_rdata;
      nTests++;
      if (d_req_ready !== gd) begin
         nFail++;
         $display("[TB] FAIL d_req_ready got %b want %b at %0t", d_req_ready, gd, $time);
      end
      nTests++;
      if (i_req_ready !== gi) begin
         nFail++;
         $display("[TB] FAIL i_req_ready got %b want %b at %0t", i_req_ready, gi, $time);
      end
      nTests++;
      if (mem_en !== (gd || gi)) begin
         nFail++;
         $display("[TB] FAIL mem_en got %b want %b at %0t", mem_en, gd || gi, $time);
      end
      nTests++;
      if (mem_we !== (gd ? dbe : 4'b0000)) begin
         nFail++;
         $display("[TB] FAIL mem_we got %h want %h at %0t", mem_we, gd ? dbe : 4'b0000, $time);
      end
      if (gd || gi) begin
         nTests++;
         if (mem_addr !== (gd ? da : ia)) begin
            nFail++;
            $display("[TB] FAIL mem_addr got %h want %h at %0t", mem_addr, gd ? da : ia, $time);
         end
      end
      if (gd && dbe != 4'b0000) begin
         nTests++;
         if (mem_din !== dw) begin
            nFail++;
            $display("[TB] FAIL mem_din got %h want %h at %0t", mem_din, dw, $time);
         end
      end
      if (!rst) begin
         nTests++;
         if (conflict_cnt !== expConflict) begin
            nFail++;
            $display("[TB] FAIL conflict_cnt got %0d want %0d at %0t", conflict_cnt, expConflict, $time);
         end
      end
      nTests++;
      if (d_resp_valid !== (expDValid && !rst)) begin
         nFail++;
         $display("[TB] FAIL d_resp_valid got %b want %b at %0t", d_resp_valid, expDValid && !rst, $time);
      end
      if (expDValid && !rst) begin
         nTests++;
         if (d_resp_rdata !== expDData) begin
            nFail++;
            $display("[TB] FAIL d_resp_rdata got %h want %h at %0t", d_resp_rdata, expDData, $time);
         end
      end
      nTests++;
      if (i_resp_valid !== (expIValid && !rst)) begin
         nFail++;
         $display("[TB] FAIL i_resp_valid got %b want %b at %0t", i_resp_valid, expIValid && !rst, $time);
      end
      if (expIValid && !rst) begin
         nTests++;
         if (i_resp_rdata !== expIData) begin
            nFail++;
            $display("[TB] FAIL i_resp_rdata got %h want %h at %0t", i_resp_rdata, expIData, $time);
         end
      end
      if (rst) begin
         expStarve   = 0;
         expConflict = '0;
         expDValid   = 1'b0;
         expIValid   = 1'b0;
      end else begin
         expDValid = 1'b0;
         expIValid = 1'b0;
         if (gd) begin
            if (dbe != 4'b0000) begin
               refMem[da[3:0]] = mergeBytes(refMem[da[3:0]], dw, dbe);
            end else begin
               expDValid = 1'b1;
               expDData  = refMem[da[3:0]];
            end
         end
         if (gi) begin
            expIValid = 1'b1;
            expIData  = refMem[ia[3:0]];
         end
         if (iv && !gi) expStarve = (expStarve + 1 > LIMIT) ? LIMIT : expStarve + 1;
         else           expStarve = 0;
         if (dv && iv) expConflict = expConflict + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_reset();
      logic [31:0] w;
      rst = 1'b1;
      for (int a = 0; a < 16; a++) begin
         case (a)
            0:       w = 32'h0000_0013;
            1:       w = 32'h0000_0093;
            2:       w = 32'h0000_0113;
            7:       w = 32'h1122_3344;
            default: w = $urandom;
         endcase
         loadEn   = 1'b1;
         loadAddr = a[3:0];
         loadData = w;
         refMem[a] = w;
         @(posedge clk);
         #1;
      end
      loadEn = 1'b0;
      step(1'b1, 12'd3, '0, 4'b0000, 1'b1, 12'd4);
      step(1'b1, 12'd3, 32'h1, 4'b1111, 1'b0, '0);
      rst = 1'b0;
      idle();
   endtask

   task automatic test_fetch_only();
      step(1'b0, '0, '0, '0, 1'b1, 12'd0);
      step(1'b0, '0, '0, '0, 1'b1, 12'd1);
      nTests++;
      if (obsIData !== 32'h13 || obsIValid !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL fetch0 got %b/%h want 1/00000013", obsIValid, obsIData);
      end
      step(1'b0, '0, '0, '0, 1'b1, 12'd2);
      nTests++;
      if (obsIData !== 32'h93) begin
         nFail++;
         $display("[TB] FAIL fetch1 got %h want 00000093", obsIData);
      end
      idle();
      nTests++;
      if (obsIData !== 32'h113) begin
         nFail++;
         $display("[TB] FAIL fetch2 got %h want 00000113", obsIData);
      end
   endtask

   task automatic test_store_load();
      step(1'b1, 12'd5, 32'hDEADBEEF, 4'b1111, 1'b0, '0);
      step(1'b1, 12'd5, '0, 4'b0000, 1'b0, '0);
      idle();
      nTests++;
      if (obsDValid !== 1'b1 || obsDData !== 32'hDEADBEEF) begin
         nFail++;
         $display("[TB] FAIL store_load got %b/%h want 1/deadbeef", obsDValid, obsDData);
      end
   endtask

   task automatic test_partial_store();
      step(1'b1, 12'd7, 32'h0000AB00, 4'b0010, 1'b0, '0);
      step(1'b1, 12'd7, '0, 4'b0000, 1'b0, '0);
      idle();
      nTests++;
      if (obsDData !== 32'h1122AB44) begin
         nFail++;
         $display("[TB] FAIL partial_store got %h want 1122ab44", obsDData);
      end
   endtask

   task automatic test_contention();
      int iGrants;
      iGrants = 0;
      for (int c = 0; c < 12; c++) begin
         step(1'b1, 12'(c % 16), '0, 4'b0000, 1'b1, 12'((c + 3) % 16));
         if (obsIReady) iGrants++;
      end
      idle();
      nTests++;
      if (conflict_cnt !== 32'd12) begin
         nFail++;
         $display("[TB] FAIL contention_conflicts got %0d want 12", conflict_cnt);
      end
      nTests++;
      if (iGrants != 2) begin
         nFail++;
         $display("[TB] FAIL contention_igrants got %0d want 2", iGrants);
      end
   endtask

   task automatic test_reset_inflight();
      step(1'b1, 12'd2, '0, 4'b0000, 1'b0, '0);
      rst = 1'b1;
      step(1'b1, 12'd1, '0, 4'b0000, 1'b1, 12'd0);
      step(1'b0, '0, '0, '0, 1'b0, '0);
      rst = 1'b0;
      idle();
      nTests++;
      if (obsDValid !== 1'b0 || conflict_cnt !== 32'd0) begin
         nFail++;
         $display("[TB] FAIL reset_inflight got valid %b cnt %0d want 0 0", obsDValid, conflict_cnt);
      end
   endtask

   task automatic test_data_only_then_fetch();
      for (int c = 0; c < 3; c++) step(1'b1, 12'(c), '0, 4'b0000, 1'b0, '0);
      step(1'b0, '0, '0, '0, 1'b1, 12'd9);
      nTests++;
      if (obsIReady !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL fetch_after_data got %b want 1", obsIReady);
      end
      for (int c = 0; c < 6; c++) step(1'b1, 12'd4, '0, 4'b0000, 1'b1, 12'd6);
      idle();
   endtask

   task automatic test_back_to_back_random();
      logic dv, iv;
      logic [3:0] be;
      for (int c = 0; c < 300; c++) begin
         dv = ($urandom_range(0, 3) != 0);
         iv = ($urandom_range(0, 3) != 0);
         be = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
         step(dv, 12'($urandom_range(0, 15)), $urandom, be, iv, 12'($urandom_range(0, 15)));
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_store_load();
      test_partial_store();
      test_contention();
      test_reset_inflight();
      test_data_only_then_fetch();
      test_back_to_back_random();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, synchronous-read BRAM between two CPU requesters: the data port (loads/stores) and the instruction-fetch port.
- Sits between the cpu pipeline and the shared BIOS/IMEM memory.
- Data requests have priority by default. A starvation counter guarantees forward progress for fetch.
- Read data returns exactly one cycle after the request is granted and is routed to the port that was granted.

Parameters:
- ADDR_WIDTH, 12, word address width into the memory.
- DATA_WIDTH, 32, data word width; byte-enable width is DATA_WIDTH/8.
- STARVE_LIMIT, 4, consecutive cycles fetch may be denied before it is forced to win.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- d_req_valid  in  1  data request present.
- d_req_ready  out  1  data request granted this cycle.
- d_req_addr  in  ADDR_WIDTH  data word address.
- d_req_wdata  in  DATA_WIDTH  store data.
- d_req_wbe  in  DATA_WIDTH/8  byte write enables; all-zero means a read.
- d_resp_valid  out  1  data read response valid.
- d_resp_rdata  out  DATA_WIDTH  data read response.
- i_req_valid  in  1  fetch request present.
- i_req_ready  out  1  fetch request granted this cycle.
- i_req_addr  in  ADDR_WIDTH  fetch word address.
- i_resp_valid  out  1  fetch response valid.
- i_resp_rdata  out  DATA_WIDTH  fetch response.
- mem_en  out  1  memory enable.
- mem_we  out  DATA_WIDTH/8  memory byte write enables.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data, valid one cycle after mem_en with mem_we==0.
- conflict_cnt  out  32  number of cycles in which both requests were valid.

Behaviour:
- Reset:
  - All registered state clears.
  - starve_cnt=0, conflict_cnt=0, pending response flags=0.
  - While rst=1: d_resp_valid=0, i_resp_valid=0, mem_en=0, mem_we=0, both readys=0.
  - Reset asserted while a read is in flight drops its response; no resp_valid is issued in the cycle after reset deasserts.
- Grant (combinational, one grant per cycle):
  - force_i = (starve_cnt >= STARVE_LIMIT).
  - Data granted when d_req_valid && !(force_i && i_req_valid).
  - Otherwise fetch granted when i_req_valid.
  - Readys are combinational from the valids and starve_cnt. A requester may drop valid at any time; there is no hold requirement.
- Memory drive (combinational):
  - mem_en = (any grant).
  - Address, wdata and wbe are muxed from the granted port. Fetch grants always drive mem_we=0.
  - With no grant: mem_en=0, mem_we=0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when i_req_valid && !i_req_ready.
  - Clears to 0 on any fetch grant, or when i_req_valid=0.
- Responses:
  - Registered flags rd_d and rd_i are set in the grant cycle.
  - rd_d = data grant && wbe==0. rd_i = fetch grant.
  - Next cycle: d_resp_valid=rd_d and i_resp_valid=rd_i. Both rdata outputs carry mem_dout unconditionally; consumers qualify with valid.
  - Latency is exactly 1 cycle, with no backpressure on responses.
  - Writes produce no response.
  - Back-to-back grants are allowed every cycle, giving full throughput.
- Write/read ordering:
  - A store granted in cycle N is visible to any read granted in cycle N+1 or later (BRAM write-first not required).
  - Same-address write followed by read the next cycle returns the new data.
- conflict_cnt increments when d_req_valid && i_req_valid; it wraps at 2^32.
- Boundaries:
  - STARVE_LIMIT=0: fetch always wins ties.
  - The forced fetch grant lasts exactly one cycle, then data priority resumes.

Decomposition:
- Shared package arb_pkg holds the port-index localparams (PORT_D=0, PORT_I=1) and the byte-enable width function.
- One natural sub-module, arb_starve_ctr: the saturating starvation counter that produces force_i.
- Grant muxing and response tracking stay in the top module.

Test Plan:
1. Fetch only, i_req_valid held high with addresses 0,1,2 and mem holding 0x13,0x93,0x113. Required: i_req_ready=1 every cycle; i_resp_rdata = 0x13,0x93,0x113 on the three following cycles.
2. Data store at addr 5: wdata 0xDEADBEEF, wbe=4'b1111. The next cycle, data read of addr 5. Required: no response for the store; d_resp_valid one cycle after the read with 0xDEADBEEF.
3. Partial store: wbe=4'b0010, wdata 0x0000AB00, onto a word holding 0x11223344. Required: a readback returns 0x1122AB44.
4. Both valid continuously for 12 cycles with STARVE_LIMIT=4. Required: the grant pattern is D,D,D,D,I repeating; conflict_cnt=12; i_resp_valid exactly on the cycles following I grants.
5. Read granted, then rst asserted on the next edge. Required: d_resp_valid=0, mem_en=0 and conflict_cnt=0 after reset; no stale response once rst deasserts.
6. Data valid for 3 cycles while i_req_valid=0. Required: starve_cnt stays 0. Fetch then arriving alone is granted immediately.
